// File: rtl/cdb_arbiter_if.sv
// Common Data Bus port bundle: per-unit result requests in, registered broadcast out.
// master = the functional units / snoopers side, slave = the arbiter.
interface cdb_arbiter_if #(
    parameter int NREQ = 6,
    parameter int DW   = 32,
    parameter int TW   = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*TW-1:0] req_tag;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               cdb_valid;
    logic [TW-1:0]      cdb_tag;
    logic [DW-1:0]      cdb_data;
    logic [NREQ-1:0]    cdb_src;
    logic [2:0]         pending;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, pending
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, pending
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Purpose: one-entry holding buffer per unit, round-robin grant of the Common Data Bus.
// Latency: result accepted at edge n is broadcast after edge n+1 when uncontended.
// Backpressure: req_ready[i] drops while buffer i is full and not granted; the unit holds its result.
module cdb_arbiter #(
    parameter int NREQ = 6,
    parameter int DW   = 32,
    parameter int TW   = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    cdb_arbiter_if.slave  bus
);
    localparam int             PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0]  LAST = PW'(NREQ - 1);

    logic [NREQ-1:0] full_q;
    logic [TW-1:0]   tag_q  [NREQ];
    logic [DW-1:0]   data_q [NREQ];
    logic [PW-1:0]   rr_ptr;

    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] full_next;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [2:0]      pend_next;

    // Scan from rr_ptr upward with wrap; first full buffer wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && full_q[idx]) begin
                gnt_any      = 1'b1;
                gnt_idx      = PW'(idx);
                gnt[idx]     = 1'b1;
            end
        end
    end

    // A granted buffer drains this edge, so it may take a new result at the same time.
    assign bus.req_ready = ~full_q | gnt;
    assign acc           = bus.req_valid & bus.req_ready;
    assign full_next     = acc | (full_q & ~gnt);

    always_comb begin
        pend_next = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend_next = pend_next + 3'(full_next[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q        <= '0;
            rr_ptr        <= '0;
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag   <= '0;
            bus.cdb_data  <= '0;
            bus.cdb_src   <= '0;
            bus.pending   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            full_q      <= full_next;
            bus.pending <= pend_next;
            bus.cdb_src <= gnt;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    tag_q[i]  <= bus.req_tag[i*TW +: TW];
                    data_q[i] <= bus.req_data[i*DW +: DW];
                end
            end
            if (gnt_any) begin
                rr_ptr        <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                bus.cdb_valid <= 1'b1;
                bus.cdb_tag   <= tag_q[gnt_idx];
                bus.cdb_data  <= data_q[gnt_idx];
            end else begin
                bus.cdb_valid <= 1'b0;
                bus.cdb_tag   <= '0;
                bus.cdb_data  <= '0;
            end
        end
    end
endmodule
